// File: rtl/demux_stream_dispatcher.sv
// ---------------------------------------------------------------------------
// demux_stream_dispatcher
//
// Round-robin dispatcher that owns the select of a 4-way demux. Words come in
// over a single valid/ready handshake, sit in a one-entry output register and
// are steered to consumer channels a..d in rotating order. Disabled channels
// are skipped.
//
// Optional feature, enabled by defining DEMUX_DISPATCH_REDIRECT_EN:
//   a held word that has stalled STALL_LIMIT cycles is re-steered to the next
//   enabled channel, and a one-cycle redirect pulse is raised. Without the
//   macro the held word waits indefinitely and redirect is tied low.
//
// Parameters:
//   BUS_WIDTH    data word width
//   STALL_LIMIT  stalled cycles before redirect (1..255, redirect build only)
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_data      source word
//   in_valid     source word valid
//   in_ready     dispatcher can accept (combinational)
//   chan_en      per-channel enable, bit 0 = a .. bit 3 = d
//   sel          registered demux select (0=a .. 3=d)
//   out_data     registered held word, feeds the demux data input
//   out_valid    one-hot valid at bit sel while a word is held
//   out_ready    per-channel consumer ready (only bit sel matters)
//   dispatch_cnt completed output transfers, wraps at 16 bits
//   redirect     one-cycle pulse when a held word is redirected
// ---------------------------------------------------------------------------
module demux_stream_dispatcher #(
  parameter int BUS_WIDTH   = 8,
  parameter int STALL_LIMIT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           chan_en,
  output logic [1:0]           sel,
  output logic [BUS_WIDTH-1:0] out_data,
  output logic [3:0]           out_valid,
  input  logic [3:0]           out_ready,
  output logic [15:0]          dispatch_cnt,
  output logic                 redirect
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  // Reject an out-of-range stall limit at elaboration time.
  if ((STALL_LIMIT < 1) || (STALL_LIMIT > 255)) begin : g_stall_limit_check
    $error("demux_stream_dispatcher: STALL_LIMIT must be within 1..255");
  end

  // First enabled channel searching start, start+1, ... mod 4.
  // Result is {found, index}; iterating from the farthest offset down lets
  // the nearest enabled channel win.
  function automatic logic [2:0] pick_channel(input logic [3:0] en,
                                              input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      res = en[idx] ? {1'b1, idx} : res;
    end
    return res;
  endfunction

  // Channel index to one-hot valid vector.
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] res;
    case (idx)
      2'd0:    res = 4'b0001;
      2'd1:    res = 4'b0010;
      2'd2:    res = 4'b0100;
      2'd3:    res = 4'b1000;
      default: res = 4'b0000;
    endcase
    return res;
  endfunction

  logic [0:0]           state_r;
  logic [1:0]           sel_r;
  logic [BUS_WIDTH-1:0] data_r;
  logic [1:0]           ptr_r;
  logic [15:0]          cnt_r;
  logic [3:0]           valid_r;

  logic [0:0]           state_nxt_s;
  logic [1:0]           sel_nxt_s;
  logic [BUS_WIDTH-1:0] data_nxt_s;
  logic [1:0]           ptr_nxt_s;
  logic [15:0]          cnt_nxt_s;
  logic [3:0]           valid_nxt_s;

  logic [2:0]           tgt_s;
  logic                 in_ready_s;
  logic                 accept_s;
  logic                 complete_s;

`ifdef DEMUX_DISPATCH_REDIRECT_EN
  localparam logic [7:0] STALL_MAX = 8'(STALL_LIMIT);

  logic [7:0] stall_r;
  logic [7:0] stall_nxt_s;
  logic       redirect_r;
  logic       redirect_nxt_s;
  logic [2:0] alt_s;
  logic       stall_hit_s;
`endif

  // Target for a new word, always evaluated with the pre-update pointer.
  assign tgt_s      = pick_channel(chan_en, ptr_r);
  assign complete_s = (state_r == ST_FULL) && out_ready[sel_r];
  assign accept_s   = in_valid && in_ready_s;

  // Upstream ready: a target must exist and the output slot must be free or
  // draining this cycle.
  always_comb begin
    in_ready_s = 1'b0;
    if (rst) begin
      in_ready_s = 1'b0;
    end else if (!tgt_s[2]) begin
      in_ready_s = 1'b0;
    end else if (state_r == ST_EMPTY) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = out_ready[sel_r];
    end
  end

`ifdef DEMUX_DISPATCH_REDIRECT_EN
  // Alternative channel excludes the current one and starts just after it.
  assign alt_s       = pick_channel(chan_en & ~onehot4(sel_r), sel_r + 2'd1);
  // Fires on the stalled cycle that brings the count up to the limit, and on
  // every later stalled cycle while the count sits saturated.
  assign stall_hit_s = (({1'b0, stall_r} + 9'd1) >= {1'b0, STALL_MAX});
`endif

  // Next-state logic for the output slot, pointer and transfer counter.
  always_comb begin
    state_nxt_s = state_r;
    sel_nxt_s   = sel_r;
    data_nxt_s  = data_r;
    ptr_nxt_s   = ptr_r;
    cnt_nxt_s   = cnt_r;
`ifdef DEMUX_DISPATCH_REDIRECT_EN
    stall_nxt_s    = stall_r;
    redirect_nxt_s = 1'b0;
`endif

    if (accept_s) begin
      state_nxt_s = ST_FULL;
      sel_nxt_s   = tgt_s[1:0];
      data_nxt_s  = in_data;
      ptr_nxt_s   = tgt_s[1:0] + 2'd1;
    end else if (complete_s) begin
      state_nxt_s = ST_EMPTY;
    end else begin
      state_nxt_s = state_r;
    end

    if (complete_s) begin
      cnt_nxt_s = cnt_r + 16'd1;
    end else begin
      cnt_nxt_s = cnt_r;
    end

`ifdef DEMUX_DISPATCH_REDIRECT_EN
    // Accept while FULL implies completion, so a stall here is a true stall.
    if (accept_s || complete_s || (state_r == ST_EMPTY)) begin
      stall_nxt_s = 8'd0;
    end else if (stall_hit_s && alt_s[2]) begin
      sel_nxt_s      = alt_s[1:0];
      ptr_nxt_s      = alt_s[1:0] + 2'd1;
      stall_nxt_s    = 8'd0;
      redirect_nxt_s = 1'b1;
    end else if (stall_r < STALL_MAX) begin
      stall_nxt_s = stall_r + 8'd1;
    end else begin
      stall_nxt_s = stall_r;
    end
`endif

    if (state_nxt_s == ST_FULL) begin
      valid_nxt_s = onehot4(sel_nxt_s);
    end else begin
      valid_nxt_s = 4'b0000;
    end
  end

  // Output slot, pointer and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_EMPTY;
      sel_r   <= 2'd0;
      data_r  <= '0;
      ptr_r   <= 2'd0;
      cnt_r   <= 16'd0;
      valid_r <= 4'b0000;
    end else begin
      state_r <= state_nxt_s;
      sel_r   <= sel_nxt_s;
      data_r  <= data_nxt_s;
      ptr_r   <= ptr_nxt_s;
      cnt_r   <= cnt_nxt_s;
      valid_r <= valid_nxt_s;
    end
  end

`ifdef DEMUX_DISPATCH_REDIRECT_EN
  // Stall counter and redirect pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_r    <= 8'd0;
      redirect_r <= 1'b0;
    end else begin
      stall_r    <= stall_nxt_s;
      redirect_r <= redirect_nxt_s;
    end
  end

  assign redirect = redirect_r;
`else
  assign redirect = 1'b0;
`endif

  assign in_ready     = in_ready_s;
  assign sel          = sel_r;
  assign out_data     = data_r;
  assign out_valid    = valid_r;
  assign dispatch_cnt = cnt_r;

endmodule

// File: tb/tb_demux_stream_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_demux_stream_dispatcher
//
// Directed bench for demux_stream_dispatcher with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled at
// the same point, well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_demux_stream_dispatcher;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  chan_en;
  logic [1:0]  sel;
  logic [7:0]  out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [15:0] dispatch_cnt;
  logic        redirect;

  int n_checks;
  int n_errors;

  demux_stream_dispatcher #(
    .BUS_WIDTH  (8),
    .STALL_LIMIT(3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .chan_en     (chan_en),
    .sel         (sel),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .dispatch_cnt(dispatch_cnt),
    .redirect    (redirect)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed stimulus.
  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    chan_en   = 4'hF;
    out_ready = 4'hF;
    tick();
    tick();
    check_val("rst_in_ready", 32'(in_ready), 32'h0);
    rst = 1'b0;
    #1;
    check_val("reset_sel",      32'(sel),          32'h0);
    check_val("reset_valid",    32'(out_valid),    32'h0);
    check_val("reset_data",     32'(out_data),     32'h0);
    check_val("reset_cnt",      32'(dispatch_cnt), 32'h0);
    check_val("reset_redirect", 32'(redirect),     32'h0);
    check_val("reset_in_ready", 32'(in_ready),     32'h1);

    // All channels enabled, back-to-back stream 0x10..0x17.
    for (int i = 0; i < 8; i++) begin
      in_data  = 8'(8'h10 + i);
      in_valid = 1'b1;
      #1;
      check_val("rr_in_ready", 32'(in_ready), 32'h1);
      tick();
      check_val("rr_sel",   32'(sel),          32'(i % 4));
      check_val("rr_data",  32'(out_data),     32'(8'h10 + i));
      check_val("rr_valid", 32'(out_valid),    32'(4'b0001 << (i % 4)));
      check_val("rr_cnt",   32'(dispatch_cnt), 32'(i));
    end
    in_valid = 1'b0;
    tick();
    check_val("rr_final_cnt",   32'(dispatch_cnt), 32'd8);
    check_val("rr_final_valid", 32'(out_valid),    32'h0);

    // Only b and d enabled: expect sel 1,3,1,3.
    chan_en = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      in_data  = 8'(8'h20 + i);
      in_valid = 1'b1;
      tick();
      check_val("skip_sel",   32'(sel),       (i % 2 == 0) ? 32'h1 : 32'h3);
      check_val("skip_valid", 32'(out_valid), (i % 2 == 0) ? 32'h2 : 32'h8);
      check_val("skip_data",  32'(out_data),  32'(8'h20 + i));
    end
    in_valid = 1'b0;
    tick();
    check_val("skip_cnt", 32'(dispatch_cnt), 32'd12);

    // Backpressure on a (only channel enabled, so nothing can be redirected).
    chan_en   = 4'b0001;
    out_ready = 4'b1110;
    in_data   = 8'hA5;
    in_valid  = 1'b1;
    tick();
    in_data = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_val("stall_in_ready", 32'(in_ready), 32'h0);
      tick();
      check_val("stall_data",     32'(out_data),     32'hA5);
      check_val("stall_sel",      32'(sel),          32'h0);
      check_val("stall_valid",    32'(out_valid),    32'h1);
      check_val("stall_cnt",      32'(dispatch_cnt), 32'd12);
      check_val("stall_redirect", 32'(redirect),     32'h0);
    end
    in_valid  = 1'b0;
    out_ready = 4'hF;
    tick();
    check_val("unstall_cnt",   32'(dispatch_cnt), 32'd13);
    check_val("unstall_valid", 32'(out_valid),    32'h0);

    // No enabled channel: nothing accepted.
    chan_en  = 4'b0000;
    in_data  = 8'h77;
    in_valid = 1'b1;
    #1;
    check_val("noen_in_ready", 32'(in_ready), 32'h0);
    tick();
    check_val("noen_valid", 32'(out_valid),    32'h0);
    check_val("noen_cnt",   32'(dispatch_cnt), 32'd13);

    // Reset while FULL; pointer is at b after the word on a.
    chan_en  = 4'hF;
    in_data  = 8'h99;
    tick();
    check_val("prerst_sel",   32'(sel),       32'h1);
    check_val("prerst_valid", 32'(out_valid), 32'h2);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check_val("midrst_in_ready", 32'(in_ready), 32'h0);
    tick();
    check_val("rst_full_valid", 32'(out_valid),    32'h0);
    check_val("rst_full_sel",   32'(sel),          32'h0);
    check_val("rst_full_cnt",   32'(dispatch_cnt), 32'h0);
    check_val("rst_full_data",  32'(out_data),     32'h0);
    rst = 1'b0;

    // Counter wrap: 65536 back-to-back accepts complete 65535 words.
    in_data  = 8'h42;
    in_valid = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      @(posedge clk);
    end
    #1;
    check_val("wrap_pre_cnt", 32'(dispatch_cnt), 32'hFFFF);
    in_valid = 1'b0;
    tick();
    check_val("wrap_cnt", 32'(dispatch_cnt), 32'h0);

    // Word 0x3C held on c while c is not ready; pointer starts at a.
    chan_en   = 4'b1100;
    out_ready = 4'b1011;
    in_data   = 8'h3C;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    chan_en  = 4'hF;
    check_val("hold_sel",   32'(sel),       32'h2);
    check_val("hold_valid", 32'(out_valid), 32'h4);
`ifdef DEMUX_DISPATCH_REDIRECT_EN
    for (int i = 0; i < 2; i++) begin
      tick();
      check_val("pre_redir_sel",      32'(sel),      32'h2);
      check_val("pre_redir_redirect", 32'(redirect), 32'h0);
    end
    tick();
    check_val("redir_sel",      32'(sel),       32'h3);
    check_val("redir_redirect", 32'(redirect),  32'h1);
    check_val("redir_valid",    32'(out_valid), 32'h8);
    check_val("redir_data",     32'(out_data),  32'h3C);
    tick();
    check_val("redir_done_redirect", 32'(redirect),     32'h0);
    check_val("redir_done_valid",    32'(out_valid),    32'h0);
    check_val("redir_done_cnt",      32'(dispatch_cnt), 32'h1);
`else
    for (int i = 0; i < 6; i++) begin
      tick();
      check_val("wait_sel",      32'(sel),          32'h2);
      check_val("wait_data",     32'(out_data),     32'h3C);
      check_val("wait_redirect", 32'(redirect),     32'h0);
      check_val("wait_cnt",      32'(dispatch_cnt), 32'h0);
    end
    out_ready = 4'hF;
    tick();
    check_val("wait_done_valid", 32'(out_valid),    32'h0);
    check_val("wait_done_cnt",   32'(dispatch_cnt), 32'h1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/demux_stream_dispatcher.md
# demux_stream_dispatcher

Round-robin stream dispatcher that owns the select input of the 4-way N-bit demux. It accepts words from a single valid/ready source, holds each in a one-entry output register and steers it to one of four consumer channels (a..d) in rotating order, skipping disabled channels. It sits between the upstream producer and the demux/consumer side and is the only block allowed to drive the demux select.

## Interface
- BUS_WIDTH, 8, data word width
- STALL_LIMIT, 15, consecutive stalled cycles before redirect (used only with the redirect feature; legal range 1..255)

- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  BUS_WIDTH  source word
- in_valid  input  1  source word valid
- in_ready  output  1  dispatcher can accept (combinational)
- chan_en  input  4  per-channel enable, bit 0 = a … bit 3 = d
- sel  output  2  registered demux select (0=a,1=b,2=c,3=d)
- out_data  output  BUS_WIDTH  registered word, feeds demux y
- out_valid  output  4  one-hot valid, bit = sel when holding, else 0
- out_ready  input  4  per-channel consumer ready
- dispatch_cnt  output  16  completed output transfers, wraps
- redirect  output  1  one-cycle pulse when a held word is redirected

## Operation
- Two states: EMPTY, FULL. Reset: EMPTY, sel=0, out_data=0, out_valid=0, rotation pointer ptr=0, dispatch_cnt=0, redirect=0, stall counter=0.
- Target = first channel with chan_en set, searching ptr, ptr+1, … mod 4. No enabled channel → no target.
- in_ready = !rst && target exists && (EMPTY || out_ready[sel]).
- Accept (in_valid && in_ready): out_data <= in_data, sel <= target, ptr <= target+1 mod 4, state FULL.
- FULL: out_valid = 1<<sel. Transfer completes when out_ready[sel]=1: dispatch_cnt += 1; if same-cycle accept, reload (stay FULL), else go EMPTY.
- Target is evaluated with ptr before the same-cycle update; simultaneous complete + accept uses the pre-update ptr.
- chan_en changes do not move a held word; it waits on its sel channel (except redirect).
- out_ready on channels other than sel is ignored.
- rst asserted mid-transfer drops the held word; all outputs return to reset values next edge.

## Timing
- Latency: word accepted at edge N appears on out_data/out_valid after edge N, i.e. during cycle N+1.
- Throughput: 1 word/cycle while target consumer keeps out_ready high.
- sel, out_data, out_valid, dispatch_cnt, redirect are registered; in_ready is the only combinational output.
- out_data and sel are stable while out_valid is nonzero and the transfer has not completed.
- dispatch_cnt wraps 16'hFFFF → 0.

## Configuration
- Macro DEMUX_DISPATCH_REDIRECT_EN.
- Defined: in FULL, stall counter increments each cycle with out_ready[sel]=0, clears on completion or accept. When it reaches STALL_LIMIT and another enabled channel exists (search sel+1, sel+2, sel+3 mod 4 over chan_en), next edge sel <= that channel, ptr <= it+1, counter clears, redirect pulses 1 cycle. out_data unchanged. No other enabled channel → keep waiting, counter saturates.
- Not defined: no stall counter; held word waits indefinitely; redirect tied to 0.

## Test plan
- Reset, chan_en=4'hF, all out_ready=1, stream 8 words 0x10..0x17 back-to-back → sel 0,1,2,3,0,1,2,3, one word/cycle, dispatch_cnt=8.
- chan_en=4'b1010, stream 4 words → sel 1,3,1,3; out_valid bits 0/2 never set.
- out_ready[0]=0 for 5 cycles with word 0xA5 on sel=0 → out_data/sel stable, in_ready=0, then out_ready[0]=1 → transfer, dispatch_cnt+1.
- chan_en=0 with in_valid=1 → in_ready=0, no accept; assert rst while FULL → out_valid=0, sel=0, dispatch_cnt=0 next cycle.
- Preload dispatch_cnt to 0xFFFF via 65535 transfers (or forced), one more transfer → 0.
- With DEMUX_DISPATCH_REDIRECT_EN, STALL_LIMIT=3, chan_en=4'hF, word 0x3C held on sel=2, out_ready[2]=0 → after 3 stalled cycles sel=3, redirect pulses once, 0x3C delivered on d.
